// File: rtl/ls153_scan_ctrl_if.sv
// Pin bundle between the scan sequencer and an SN54LS153 dual 4-to-1 mux plus its result consumer.
// master is the sequencer; slave is the mux/consumer side.
interface ls153_scan_ctrl_if;
    logic       i_start;
    logic       i_cont;
    logic       i_1Y;
    logic       i_2Y;
    logic       o_B;
    logic       o_A;
    logic       o_1G_n;
    logic       o_2G_n;
    logic [3:0] o_word1;
    logic [3:0] o_word2;
    logic       o_valid;
    logic       o_busy;

    modport master (
        input  i_start, i_cont, i_1Y, i_2Y,
        output o_B, o_A, o_1G_n, o_2G_n, o_word1, o_word2, o_valid, o_busy
    );

    modport slave (
        output i_start, i_cont, i_1Y, i_2Y,
        input  o_B, o_A, o_1G_n, o_2G_n, o_word1, o_word2, o_valid, o_busy
    );
endinterface

// File: rtl/ls153_scan_ctrl.sv
// Steps an SN54LS153 through channels 0..3, samples both Y outputs after DWELL cycles each.
// Start to o_valid is 4*DWELL+1 cycles; no backpressure, results are a one-cycle pulse.
module ls153_scan_ctrl #(
    parameter int DWELL = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    ls153_scan_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

    state_t     state, state_nxt;
    logic [1:0] ch, ch_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [3:0] sh1, sh1_nxt;
    logic [3:0] sh2, sh2_nxt;

    logic       strobe_n;
    logic       valid;
    logic       busy;
    logic [3:0] word1;
    logic [3:0] word2;

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        cnt_nxt   = cnt;
        sh1_nxt   = sh1;
        sh2_nxt   = sh2;
        case (state)
            IDLE: begin
                ch_nxt  = 2'd0;
                cnt_nxt = 8'd0;
                if (bus.i_start) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (cnt == CNT_LAST) begin
                    sh1_nxt[ch] = bus.i_1Y;
                    sh2_nxt[ch] = bus.i_2Y;
                    cnt_nxt     = 8'd0;
                    if (ch == 2'd3) begin
                        state_nxt = DONE;
                        ch_nxt    = 2'd0;
                    end else begin
                        ch_nxt = ch + 2'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            DONE: begin
                ch_nxt    = 2'd0;
                cnt_nxt   = 8'd0;
                state_nxt = bus.i_cont ? SCAN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
                ch_nxt    = 2'd0;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Outputs are registered from the next-state view so each one lines up with its state.
    // The channel-3 sample lands in the words on the same edge it is taken.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            ch       <= 2'd0;
            cnt      <= 8'd0;
            sh1      <= 4'd0;
            sh2      <= 4'd0;
            strobe_n <= 1'b1;
            valid    <= 1'b0;
            busy     <= 1'b0;
            word1    <= 4'd0;
            word2    <= 4'd0;
        end else begin
            state    <= state_nxt;
            ch       <= ch_nxt;
            cnt      <= cnt_nxt;
            sh1      <= sh1_nxt;
            sh2      <= sh2_nxt;
            strobe_n <= (state_nxt != SCAN);
            valid    <= (state_nxt == DONE);
            busy     <= (state_nxt != IDLE);
            if (state_nxt == DONE) begin
                word1 <= sh1_nxt;
                word2 <= sh2_nxt;
            end
        end
    end

    assign bus.o_B     = ch[1];
    assign bus.o_A     = ch[0];
    assign bus.o_1G_n  = strobe_n;
    assign bus.o_2G_n  = strobe_n;
    assign bus.o_word1 = word1;
    assign bus.o_word2 = word2;
    assign bus.o_valid = valid;
    assign bus.o_busy  = busy;

endmodule
